// File: rtl/cache_refill.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill
// Brief    : Cache-miss refill engine: stalls the CPU, reads the missing line
//            from data memory word by word and writes it into the cache.
//            Option macro CACHE_REFILL_CWF_EN enables critical-word-first.
// Revision : 1.0
// ============================================================================
module cache_refill #(
    parameter int LINE_WORDS = 4,
    parameter int MEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        miss,
    input  logic [7:0]  miss_addr,
    input  logic [15:0] mem_rdata,
    output logic [7:0]  mem_addr,
    output logic        mem_re,
    output logic        cache_we,
    output logic [7:0]  cache_waddr,
    output logic [15:0] cache_wdata,
    output logic        stall,
    output logic        done,
    output logic        fwd_valid,
    output logic [15:0] fwd_data,
    output logic [15:0] miss_count
);

    localparam int                c_OFFW      = $clog2(LINE_WORDS);
    localparam logic [2:0]        c_LAT_LAST  = 3'(MEM_LAT);
    localparam logic [c_OFFW-1:0] c_FILL_LAST = c_OFFW'(LINE_WORDS - 1);

`ifdef CACHE_REFILL_CWF_EN
    localparam bit c_CWF_EN = 1'b1;
`else
    localparam bit c_CWF_EN = 1'b0;
`endif

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [7-c_OFFW:0] r_tag;
    logic [c_OFFW-1:0] r_off;
    logic [c_OFFW-1:0] r_fill;
    logic [2:0]        r_lat;
    logic [15:0]       r_data;
    logic [15:0]       r_count;
    logic [c_OFFW-1:0] w_start;
    logic [7:0]        w_word;

    // Fill starts at the missing word only when critical-word-first is built in
    assign w_start    = miss_addr[c_OFFW-1:0] & {c_OFFW{c_CWF_EN}};
    assign w_word     = {r_tag, r_off};
    assign miss_count = r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (miss) w_next = c_ISSUE;
            c_ISSUE: w_next = c_WAIT;
            c_WAIT:  if (r_lat == c_LAT_LAST) w_next = c_WRITE;
            c_WRITE: w_next = (r_fill == c_FILL_LAST) ? c_DONE : c_ISSUE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag   <= '0;
            r_off   <= '0;
            r_fill  <= '0;
            r_lat   <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (miss) begin
                        r_tag  <= miss_addr[7:c_OFFW];
                        r_off  <= w_start;
                        r_fill <= '0;
                        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                    end
                end
                c_ISSUE: r_lat <= 3'd1;
                c_WAIT: begin
                    if (r_lat == c_LAT_LAST) r_data <= mem_rdata;
                    else                     r_lat  <= r_lat + 3'd1;
                end
                c_WRITE: begin
                    r_fill <= r_fill + 1'b1;
                    r_off  <= r_off + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr    = '0;
        mem_re      = 1'b0;
        cache_we    = 1'b0;
        cache_waddr = '0;
        cache_wdata = '0;
        stall       = 1'b0;
        done        = 1'b0;
        fwd_valid   = 1'b0;
        fwd_data    = '0;
        case (r_state)
            c_IDLE:  stall = miss;
            c_ISSUE: begin
                stall    = 1'b1;
                mem_re   = 1'b1;
                mem_addr = w_word;
            end
            c_WAIT: begin
                stall    = 1'b1;
                mem_addr = w_word;
            end
            c_WRITE: begin
                stall       = 1'b1;
                cache_we    = 1'b1;
                cache_waddr = w_word;
                cache_wdata = r_data;
`ifdef CACHE_REFILL_CWF_EN
                if (r_fill == '0) begin
                    fwd_valid = 1'b1;
                    fwd_data  = r_data;
                end
`endif
            end
            c_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill
// Brief    : Self-checking bench for cache_refill: two parameterisations,
//            cycle-accurate reference derived from the refill timing rules.
// Revision : 1.0
// ============================================================================
module tb_cache_refill;

    localparam int LW0 = 4, LAT0 = 1;
    localparam int LW1 = 2, LAT1 = 3;
`ifdef CACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        miss      [2];
    logic [7:0]  miss_addr [2];
    logic [15:0] mem_rdata [2];
    logic [7:0]  mem_addr  [2];
    logic        mem_re    [2];
    logic        cache_we  [2];
    logic [7:0]  cache_waddr [2];
    logic [15:0] cache_wdata [2];
    logic        stall     [2];
    logic        done      [2];
    logic        fwd_valid [2];
    logic [15:0] fwd_data  [2];
    logic [15:0] miss_count [2];

    logic [15:0] mem [256];
    logic [15:0] cnt_model [2];
    int          n_checks = 0;
    int          n_err    = 0;

    always #5 clk = ~clk;

    assign mem_rdata[0] = mem[mem_addr[0]];
    assign mem_rdata[1] = mem[mem_addr[1]];

    cache_refill #(.LINE_WORDS(LW0), .MEM_LAT(LAT0)) u0 (
        .clk(clk), .reset(reset), .miss(miss[0]), .miss_addr(miss_addr[0]),
        .mem_rdata(mem_rdata[0]), .mem_addr(mem_addr[0]), .mem_re(mem_re[0]),
        .cache_we(cache_we[0]), .cache_waddr(cache_waddr[0]), .cache_wdata(cache_wdata[0]),
        .stall(stall[0]), .done(done[0]), .fwd_valid(fwd_valid[0]), .fwd_data(fwd_data[0]),
        .miss_count(miss_count[0])
    );

    cache_refill #(.LINE_WORDS(LW1), .MEM_LAT(LAT1)) u1 (
        .clk(clk), .reset(reset), .miss(miss[1]), .miss_addr(miss_addr[1]),
        .mem_rdata(mem_rdata[1]), .mem_addr(mem_addr[1]), .mem_re(mem_re[1]),
        .cache_we(cache_we[1]), .cache_waddr(cache_waddr[1]), .cache_wdata(cache_wdata[1]),
        .stall(stall[1]), .done(done[1]), .fwd_valid(fwd_valid[1]), .fwd_data(fwd_data[1]),
        .miss_count(miss_count[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        check($sformatf("%s u%0d mem_re", tag, i), 32'(mem_re[i]), 0);
        check($sformatf("%s u%0d mem_addr", tag, i), 32'(mem_addr[i]), 0);
        check($sformatf("%s u%0d cache_we", tag, i), 32'(cache_we[i]), 0);
        check($sformatf("%s u%0d cache_waddr", tag, i), 32'(cache_waddr[i]), 0);
        check($sformatf("%s u%0d cache_wdata", tag, i), 32'(cache_wdata[i]), 0);
        check($sformatf("%s u%0d done", tag, i), 32'(done[i]), 0);
        check($sformatf("%s u%0d fwd_valid", tag, i), 32'(fwd_valid[i]), 0);
        check($sformatf("%s u%0d fwd_data", tag, i), 32'(fwd_data[i]), 0);
        check($sformatf("%s u%0d miss_count", tag, i), 32'(miss_count[i]), 32'(cnt_model[i]));
    endtask

    // One refill for instance i, entered at a falling edge with the engine idle.
    // abort_c >= 0 pulls reset low after checking that cycle and returns early.
    task automatic run_fill(input int i, input logic [7:0] addr, input bit hold, input int abort_c);
        int lw, lat, p, f, k, ph, start;
        logic [7:0]  base, wa;
        logic [15:0] e_cnt;
        lw    = (i == 0) ? LW0 : LW1;
        lat   = (i == 0) ? LAT0 : LAT1;
        p     = lat + 2;
        f     = lw * p;
        base  = addr & ~8'(lw - 1);
        start = CWF ? int'(addr) % lw : 0;
        e_cnt = (cnt_model[i] == 16'hFFFF) ? 16'hFFFF : cnt_model[i] + 16'd1;
        for (int c = 0; c <= f + 1; c++) begin
            logic        e_re, e_we, e_fv;
            logic [7:0]  e_ma, e_wa;
            logic [15:0] e_wd, e_fd;
            if (c == 0) begin
                miss[i]      = 1'b1;
                miss_addr[i] = addr;
            end else begin
                miss_addr[i] = 8'($urandom);
            end
            e_re = 0; e_we = 0; e_fv = 0; e_ma = 0; e_wa = 0; e_wd = 0; e_fd = 0;
            if (c >= 1 && c <= f) begin
                k  = (c - 1) / p;
                ph = (c - 1) % p;
                wa = base + 8'((start + k) % lw);
                if (ph <= lat) e_ma = wa;
                if (ph == 0) e_re = 1;
                if (ph == lat + 1) begin
                    e_we = 1; e_wa = wa; e_wd = mem[wa];
                    if (CWF && k == 0) begin e_fv = 1; e_fd = mem[wa]; end
                end
            end
            #1;
            check($sformatf("u%0d c%0d stall", i, c), 32'(stall[i]), 32'(c <= f));
            check($sformatf("u%0d c%0d done", i, c), 32'(done[i]), 32'(c == f + 1));
            check($sformatf("u%0d c%0d mem_re", i, c), 32'(mem_re[i]), 32'(e_re));
            check($sformatf("u%0d c%0d mem_addr", i, c), 32'(mem_addr[i]), 32'(e_ma));
            check($sformatf("u%0d c%0d cache_we", i, c), 32'(cache_we[i]), 32'(e_we));
            check($sformatf("u%0d c%0d cache_waddr", i, c), 32'(cache_waddr[i]), 32'(e_wa));
            check($sformatf("u%0d c%0d cache_wdata", i, c), 32'(cache_wdata[i]), 32'(e_wd));
            check($sformatf("u%0d c%0d fwd_valid", i, c), 32'(fwd_valid[i]), 32'(e_fv));
            check($sformatf("u%0d c%0d fwd_data", i, c), 32'(fwd_data[i]), 32'(e_fd));
            check($sformatf("u%0d c%0d miss_count", i, c), 32'(miss_count[i]),
                  32'((c == 0) ? cnt_model[i] : e_cnt));
            if (c == abort_c) begin
                cnt_model[i] = e_cnt;
                reset = 1'b0;
                miss[i] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        cnt_model[i] = e_cnt;
        miss[i] = hold;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);
        miss[0] = 1'b1; miss[1] = 1'b1;
        miss_addr[0] = 8'h55; miss_addr[1] = 8'hAA;
        cnt_model[0] = '0; cnt_model[1] = '0;

        // Reset held while a miss is asserted
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle(0, "reset");
        check_idle(1, "reset");
        reset = 1'b1;
        miss[0] = 1'b0; miss[1] = 1'b0;
        @(negedge clk);
        #1;
        check("idle u0 stall", 32'(stall[0]), 0);
        check("idle u1 stall", 32'(stall[1]), 0);
        @(negedge clk);

        // Basic line fill, defaults
        run_fill(0, 8'h26, 1'b0, -1);
        #1; check("after fill u0 stall", 32'(stall[0]), 0);
        check_idle(0, "after fill");
        @(negedge clk);

        // Long latency, short line
        run_fill(1, 8'h81, 1'b0, -1);
        @(negedge clk);

        // Random contents and addresses
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        for (int n = 0; n < 6; n++) begin
            run_fill(n % 2, 8'($urandom), 1'b0, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during the second WAIT of a fill
        run_fill(0, 8'h26, 1'b0, 5);
        @(negedge clk);
        cnt_model[0] = '0; cnt_model[1] = '0;
        #1;
        check("midreset u0 stall", 32'(stall[0]), 0);
        check_idle(0, "midreset");
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check($sformatf("post-reset c%0d done", c), 32'(done[0]), 0);
            check($sformatf("post-reset c%0d cache_we", c), 32'(cache_we[0]), 0);
        end
        @(negedge clk);
        run_fill(0, 8'h26, 1'b0, -1);
        @(negedge clk);

        // Back-to-back misses with miss held through DONE
        run_fill(0, 8'($urandom), 1'b1, -1);
        run_fill(0, 8'($urandom), 1'b1, -1);
        run_fill(0, 8'($urandom), 1'b0, -1);
        @(negedge clk);

        // Saturation: preload the counter just below the limit
        force u0.r_count = 16'hFFFD;
        @(negedge clk);
        release u0.r_count;
        cnt_model[0] = 16'hFFFD;
        #1; check("sat preload miss_count", 32'(miss_count[0]), 32'hFFFD);
        @(negedge clk);
        run_fill(0, 8'($urandom), 1'b1, -1);
        run_fill(0, 8'($urandom), 1'b1, -1);
        run_fill(0, 8'($urandom), 1'b0, -1);
        #1; check("sat final miss_count", 32'(miss_count[0]), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
